// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern detector.
// Holds the FSM state encoding and the fill-counter width function.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    ARMED = 2'b11
  } det_state_t;

  function automatic int fill_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/seq_detect_fsm_if.sv
// Control/stream/status bundle of the pattern detector.
// master drives the stream, slave is the detector.
interface seq_detect_fsm_if #(
  parameter int W  = 4,
  parameter int CW = 8
);
  logic          en;
  logic          pat_load;
  logic [W-1:0]  pat_in;
  logic          overlap;
  logic          x_valid;
  logic          x;
  logic          clr_cnt;
  logic          match;
  logic          armed;
  logic [CW-1:0] match_cnt;
  logic          cnt_sat;

  modport master (
    output en, pat_load, pat_in, overlap,
    output x_valid, x, clr_cnt,
    input  match, armed, match_cnt, cnt_sat
  );

  modport slave (
    input  en, pat_load, pat_in, overlap,
    input  x_valid, x, clr_cnt,
    output match, armed, match_cnt, cnt_sat
  );
endinterface

// File: rtl/seq_detect_fsm_sat_counter.sv
// Saturating event counter with sticky saturation flag.
// A clear in the same cycle as an increment yields a count of one.
module sat_counter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          sat_o
);

  localparam logic [CW-1:0] MAX = '1;

  logic [CW-1:0] cnt_q, cnt_d, base;
  logic          sat_q, sat_d, sat_base;

  always_comb begin
    base     = clr_i ? '0 : cnt_q;
    sat_base = clr_i ? 1'b0 : sat_q;
    cnt_d    = base;
    if (inc_i && base != MAX) begin
      cnt_d = base + CW'(1);
    end
    sat_d = sat_base | (cnt_d == MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/seq_detect_fsm.sv
// Mealy serial pattern detector with loadable pattern,
// overlap control, enable gating and saturating match counter.
module seq_detect_fsm
  import seq_detect_pkg::*;
#(
  parameter int             W       = 4,
  parameter int             CW      = 8,
  parameter logic [W-1:0]   PAT_RST = 4'b1011
) (
  input logic             clk,
  input logic             rst,
  seq_detect_fsm_if.slave bus
);

  localparam int FW = fill_w(W);
  localparam logic [FW-1:0] FILL_LAST = FW'(W - 2);

  det_state_t    state_q, state_d;
  logic [W-2:0]  hist_q, hist_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [W-1:0]  pat_q, pat_d;
  logic [W-1:0]  win;
  logic          match_c;

  // window = buffered history plus the bit offered this cycle
  assign win = {hist_q, bus.x};

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    pat_d   = pat_q;
    match_c = 1'b0;
    if (!bus.en) begin
      state_d = IDLE;
      hist_d  = '0;
      fill_d  = '0;
    end else if (bus.pat_load) begin
      pat_d   = bus.pat_in;
      state_d = FILL;
      hist_d  = '0;
      fill_d  = '0;
    end else if (state_q == IDLE) begin
      state_d = FILL;
    end else if (bus.x_valid) begin
      unique case (state_q)
        FILL: begin
          hist_d = win[W-2:0];
          fill_d = fill_q + FW'(1);
          if (fill_q == FILL_LAST) begin
            state_d = ARMED;
          end
        end
        ARMED: begin
          hist_d = win[W-2:0];
          if (win == pat_q) begin
            match_c = 1'b1;
            if (!bus.overlap) begin
              state_d = FILL;
              hist_d  = '0;
              fill_d  = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          hist_d  = '0;
          fill_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_RST;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
    end
  end

  sat_counter #(
    .CW (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (match_c),
    .clr_i (bus.clr_cnt),
    .cnt_o (bus.match_cnt),
    .sat_o (bus.cnt_sat)
  );

  assign bus.match = match_c;
  assign bus.armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed vector bench for seq_detect_fsm (CW=8 main DUT,
// CW=2 companion DUT sharing the same stimulus).
module tb_seq_detect_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_detect_fsm_if #(.W(4), .CW(8)) u_if ();
  seq_detect_fsm_if #(.W(4), .CW(2)) u_if2 ();

  assign u_if2.en       = u_if.en;
  assign u_if2.pat_load = u_if.pat_load;
  assign u_if2.pat_in   = u_if.pat_in;
  assign u_if2.overlap  = u_if.overlap;
  assign u_if2.x_valid  = u_if.x_valid;
  assign u_if2.x        = u_if.x;
  assign u_if2.clr_cnt  = u_if.clr_cnt;

  seq_detect_fsm #(.W(4), .CW(8), .PAT_RST(4'b1011)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  seq_detect_fsm #(.W(4), .CW(2), .PAT_RST(4'b1011)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (u_if2)
  );

  typedef struct {
    logic       en;
    logic       ld;
    logic [3:0] pin;
    logic       ovl;
    logic       xv;
    logic       x;
    logic       clr;
    logic       m;
    logic       arm;
    logic [7:0] cnt;
  } vec_t;

  vec_t vq[$];
  logic ovl_g;
  int   tid;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t%0d v%0d got=%0h exp=%0h",
               nm, tid, idx, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic ld, input logic [3:0] pin,
                     input logic xv, input logic x, input logic clr,
                     input logic m, input logic arm, input logic [7:0] cnt);
    vec_t v;
    v.en = en; v.ld = ld; v.pin = pin; v.ovl = ovl_g;
    v.xv = xv; v.x = x; v.clr = clr;
    v.m = m; v.arm = arm; v.cnt = cnt;
    vq.push_back(v);
  endtask

  // valid bit: expected match, armed after edge, count after edge
  task automatic ab(input logic x, input logic m,
                    input logic arm, input logic [7:0] cnt);
    add(1'b1, 1'b0, 4'h0, 1'b1, x, 1'b0, m, arm, cnt);
  endtask

  task automatic ai(input logic x, input logic arm, input logic [7:0] cnt);
    add(1'b1, 1'b0, 4'h0, 1'b0, x, 1'b0, 1'b0, arm, cnt);
  endtask

  task automatic drive(input vec_t v);
    u_if.en       = v.en;
    u_if.pat_load = v.ld;
    u_if.pat_in   = v.pin;
    u_if.overlap  = v.ovl;
    u_if.x_valid  = v.xv;
    u_if.x        = v.x;
    u_if.clr_cnt  = v.clr;
  endtask

  task automatic run();
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(negedge clk);
      chk("match", i, 32'(u_if.match), 32'(vq[i].m));
      @(posedge clk);
      #1;
      chk("armed", i, 32'(u_if.armed), 32'(vq[i].arm));
      chk("cnt", i, 32'(u_if.match_cnt), 32'(vq[i].cnt));
    end
    vq.delete();
  endtask

  task automatic do_reset();
    u_if.en = 1'b0; u_if.pat_load = 1'b0; u_if.pat_in = 4'h0;
    u_if.overlap = 1'b0; u_if.x_valid = 1'b0; u_if.x = 1'b0;
    u_if.clr_cnt = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_match", 0, 32'(u_if.match), 0);
    chk("rst_armed", 0, 32'(u_if.armed), 0);
    chk("rst_cnt", 0, 32'(u_if.match_cnt), 0);
    chk("rst_sat", 0, 32'(u_if.cnt_sat), 0);
    chk("rst_cnt2", 0, 32'(u_if2.match_cnt), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: overlap, 1011011 -> matches on bits 4 and 7
    tid = 1; ovl_g = 1'b1;
    do_reset();
    ai(1'b0, 1'b0, 8'd0);
    ab(1, 0, 0, 0); ab(0, 0, 0, 0); ab(1, 0, 1, 0); ab(1, 1, 1, 1);
    ab(0, 0, 1, 1); ab(1, 0, 1, 1); ab(1, 1, 1, 2);
    run();

    // 2: non-overlap, same stream -> one match, refill
    tid = 2; ovl_g = 1'b0;
    do_reset();
    ai(1'b0, 1'b0, 8'd0);
    ab(1, 0, 0, 0); ab(0, 0, 0, 0); ab(1, 0, 1, 0); ab(1, 1, 0, 1);
    ab(0, 0, 0, 1); ab(1, 0, 0, 1); ab(1, 0, 1, 1);
    run();

    // 3: load 0110 mid-stream, offered bit would have matched 1011
    tid = 3; ovl_g = 1'b1;
    do_reset();
    ai(1'b0, 1'b0, 8'd0);
    ab(1, 0, 0, 0); ab(0, 0, 0, 0); ab(1, 0, 1, 0);
    add(1'b1, 1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    ab(0, 0, 0, 0); ab(1, 0, 0, 0); ab(1, 0, 1, 0); ab(0, 1, 1, 1);
    ab(1, 0, 1, 1); ab(1, 0, 1, 1);
    run();

    // 4: en=0 flushes history; bit in the IDLE cycle is dropped
    tid = 4; ovl_g = 1'b1;
    do_reset();
    ai(1'b0, 1'b0, 8'd0);
    ab(1, 0, 0, 0); ab(0, 0, 0, 0); ab(1, 0, 1, 0);
    add(1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    ab(1, 0, 0, 0);
    ab(1, 0, 0, 0); ab(0, 0, 0, 0); ab(1, 0, 1, 0); ab(1, 1, 1, 1);
    run();

    // 5: 13 bits, 4 matches; CW=2 DUT saturates
    tid = 5; ovl_g = 1'b1;
    do_reset();
    ai(1'b0, 1'b0, 8'd0);
    ab(1, 0, 0, 0); ab(0, 0, 0, 0); ab(1, 0, 1, 0); ab(1, 1, 1, 1);
    ab(0, 0, 1, 1); ab(1, 0, 1, 1); ab(1, 1, 1, 2);
    run();
    chk("c2_mid", 7, 32'(u_if2.match_cnt), 2);
    chk("sat2_mid", 7, 32'(u_if2.cnt_sat), 0);
    ab(0, 0, 1, 2); ab(1, 0, 1, 2); ab(1, 1, 1, 3);
    ab(0, 0, 1, 3); ab(1, 0, 1, 3); ab(1, 1, 1, 4);
    run();
    chk("c2_sat", 13, 32'(u_if2.match_cnt), 3);
    chk("sat2", 13, 32'(u_if2.cnt_sat), 1);
    chk("sat8", 13, 32'(u_if.cnt_sat), 0);
    ab(0, 0, 1, 4); ab(1, 0, 1, 4);
    add(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1);
    run();
    chk("c2_clr", 16, 32'(u_if2.match_cnt), 1);
    chk("sat2_clr", 16, 32'(u_if2.cnt_sat), 0);
    add(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    run();
    chk("c2_clr0", 17, 32'(u_if2.match_cnt), 0);

    // 6: gaps with x toggling, then async reset mid-pattern
    tid = 6; ovl_g = 1'b1;
    do_reset();
    ai(1'b0, 1'b0, 8'd0);
    ab(1, 0, 0, 0); ai(0, 0, 0);
    ab(0, 0, 0, 0); ai(1, 0, 0);
    ab(1, 0, 1, 0); ai(1, 1, 0); ai(0, 1, 0);
    ab(1, 1, 1, 1);
    ab(0, 0, 1, 1); ab(1, 0, 1, 1);
    run();
    u_if.x_valid = 1'b1;
    u_if.x = 1'b1;
    #2;
    chk("pre_rst_match", 0, 32'(u_if.match), 1);
    rst = 1'b1;
    #1;
    chk("arst_match", 0, 32'(u_if.match), 0);
    chk("arst_armed", 0, 32'(u_if.armed), 0);
    chk("arst_cnt", 0, 32'(u_if.match_cnt), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
